// File: rtl/decrypt_iterative_if.sv
// Request/response bundle for the iterative AES inverse cipher.
// The master drives start/in/key; the slave returns out/done/busy.
interface decrypt_iterative_if #(
  parameter int N = 128
);
  logic           start;
  logic [127:0]   in;
  logic [N-1:0]   key;
  logic [127:0]   out;
  logic           done;
  logic           busy;

  modport master (output start, output in, output key,
                  input  out,   input  done, input busy);
  modport slave  (input  start, input  in,  input  key,
                  output out,   output done, output busy);
endinterface

// File: rtl/decrypt_iterative.sv
// Iterative FIPS-197 inverse cipher: one round per clock, Nr+1 edges per block.
// Round keys come from a combinational key expansion fed by the key register.
module decrypt_iterative #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input logic               clk,
  input logic               rst,
  decrypt_iterative_if.slave bus
);

  localparam int NW = 4 * (Nr + 1);
  localparam int SW = 128 * (Nr + 1);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t           fsm_q;
  logic [127:0]   st_q;
  logic [3:0]     rc_q;
  logic [N-1:0]   key_q;
  logic [127:0]   out_q;
  logic           done_q;
  logic           busy_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox_calc(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // Byte k of the state sits at bits [127-8k -: 8]; k = row + 4*col.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
      o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
      o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
      o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  // Constant-input tables; synthesis folds these into ROMs.
  logic [7:0] sbox_lut  [256];
  logic [7:0] isbox_lut [256];
  for (genvar g = 0; g < 256; g++) begin : g_lut
    assign sbox_lut[g]  = sbox_calc(8'(g));
    assign isbox_lut[g] = isbox_calc(8'(g));
  end

  // In IDLE the expansion runs on the live key port so the initial AddRoundKey
  // uses rk[Nr] of the key being captured; in RUN it runs on key_q only.
  logic [N-1:0]  ks_key_d;
  logic [31:0]   w_d [NW];
  logic [31:0]   t_d;
  logic [7:0]    rcon_d;
  logic [SW-1:0] sched_d;

  assign ks_key_d = (fsm_q == IDLE) ? bus.key : key_q;

  always_comb begin
    w_d    = '{default: '0};
    t_d    = '0;
    rcon_d = 8'h01;
    for (int i = 0; i < Nk; i++)
      w_d[i] = ks_key_d[N-1-32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      t_d = w_d[i-1];
      if (i % Nk == 0) begin
        t_d    = {t_d[23:0], t_d[31:24]};
        t_d    = {sbox_lut[t_d[31:24]], sbox_lut[t_d[23:16]],
                  sbox_lut[t_d[15:8]],  sbox_lut[t_d[7:0]]} ^ {rcon_d, 24'h0};
        rcon_d = xtime(rcon_d);
      end else if (Nk > 6 && i % Nk == 4) begin
        t_d = {sbox_lut[t_d[31:24]], sbox_lut[t_d[23:16]],
               sbox_lut[t_d[15:8]],  sbox_lut[t_d[7:0]]};
      end
      w_d[i] = w_d[i-Nk] ^ t_d;
    end
    sched_d = '0;
    for (int r = 0; r <= Nr; r++)
      sched_d[SW-1-128*r -: 128] = {w_d[4*r], w_d[4*r+1], w_d[4*r+2], w_d[4*r+3]};
  end

  logic [3:0]   rk_idx_d;
  logic [127:0] rk_d;
  logic [127:0] sr_d;
  logic [127:0] sb_d;
  logic [127:0] ark_d;
  logic [127:0] st_mid_d;

  assign rk_idx_d = (fsm_q == IDLE) ? 4'(Nr) : rc_q;
  assign rk_d     = sched_d[SW-1-128*int'(rk_idx_d) -: 128];

  always_comb begin
    sr_d = inv_shift_rows(st_q);
    sb_d = '0;
    for (int b = 0; b < 16; b++)
      sb_d[127-8*b -: 8] = isbox_lut[sr_d[127-8*b -: 8]];
    ark_d    = sb_d ^ rk_d;
    st_mid_d = inv_mix_columns(ark_d);
  end

  // Stage boundary: control and round state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      rc_q   <= '0;
      key_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            key_q  <= bus.key;
            st_q   <= bus.in ^ rk_d;
            rc_q   <= 4'(Nr - 1);
            busy_q <= 1'b1;
            fsm_q  <= RUN;
          end
        end
        RUN: begin
          if (rc_q != 4'd0) begin
            st_q <= st_mid_d;
            rc_q <= rc_q - 4'd1;
          end else begin
            out_q  <= ark_d;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            fsm_q  <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_decrypt_iterative.sv
// Directed bench for decrypt_iterative with AES-128/192/256 instances.
module tb_decrypt_iterative;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start_v;
  logic [255:0] key_v;
  logic [127:0] cin;
  logic [127:0] out_v [3];
  logic [2:0]   done_v;
  logic [2:0]   busy_v;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decrypt_iterative_if #(.N(128)) if0 ();
  decrypt_iterative_if #(.N(192)) if1 ();
  decrypt_iterative_if #(.N(256)) if2 ();

  decrypt_iterative #(.N(128), .Nr(10), .Nk(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
  decrypt_iterative #(.N(192), .Nr(12), .Nk(6)) u1 (.clk(clk), .rst(rst), .bus(if1));
  decrypt_iterative #(.N(256), .Nr(14), .Nk(8)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.in    = cin;
  assign if1.in    = cin;
  assign if2.in    = cin;
  assign if0.key   = key_v[255:128];
  assign if1.key   = key_v[255:64];
  assign if2.key   = key_v;
  assign out_v[0]  = if0.out;
  assign out_v[1]  = if1.out;
  assign out_v[2]  = if2.out;
  assign done_v    = {if2.done, if1.done, if0.done};
  assign busy_v    = {if2.busy, if1.busy, if0.busy};

  typedef struct {
    int           sel;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    string        nm;
  } vec_t;

  vec_t vecs [5];

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int sel, input logic [255:0] k, input logic [127:0] ct,
                         input logic [127:0] pt, input string nm);
    int nr;
    int cnt;
    nr = 10 + 2 * sel;
    @(negedge clk);
    key_v = k;
    cin   = ct;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    cnt = 1;
    chk({nm, " busy after accept"}, 256'(busy_v[sel]), 256'd1);
    while (!done_v[sel] && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({nm, " latency"}, 256'(cnt), 256'(nr + 1));
    chk({nm, " out"}, 256'(out_v[sel]), 256'(pt));
    chk({nm, " busy at done"}, 256'(busy_v[sel]), 256'd0);
    @(posedge clk); #1;
    chk({nm, " done width"}, 256'(done_v[sel]), 256'd0);
    chk({nm, " out held"}, 256'(out_v[sel]), 256'(pt));
  endtask

  initial begin
    int cnt;
    int ndone;
    int last;
    int done_at;

    vecs[0] = '{0, K128, C128, PT, "c1_aes128"};
    vecs[1] = '{0, KB, CB, PB, "appb_aes128"};
    vecs[2] = '{0, 256'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, "zero_aes128"};
    vecs[3] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, "c2_aes192"};
    vecs[4] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, PT, "c3_aes256"};

    rst = 1'b1; start_v = '0; key_v = '0; cin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", 256'(out_v[0]), 256'd0);
    chk("reset done", 256'(done_v), 256'd0);
    chk("reset busy", 256'(busy_v), 256'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i].sel, vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].nm);

    // Start held high: three back-to-back blocks.
    @(negedge clk);
    key_v = KB; cin = CB; start_v[0] = 1'b1;
    cnt = 0; ndone = 0; last = 0;
    while (ndone < 3 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (done_v[0]) begin
        ndone++;
        chk("b2b out", 256'(out_v[0]), 256'(PB));
        chk("b2b spacing", 256'(cnt - last), 256'd11);
        last = cnt;
      end
    end
    start_v[0] = 1'b0;
    chk("b2b blocks", 256'(ndone), 256'd3);
    @(posedge clk); #1;
    chk("b2b idle after", 256'(busy_v[0]), 256'd0);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    key_v = K128; cin = C128; start_v[0] = 1'b1;
    cnt = 0; ndone = 0; done_at = 0;
    while (cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      start_v[0] = 1'b0;
      if (cnt == 4) begin
        key_v = '0; cin = '0; start_v[0] = 1'b1;
      end
      if (done_v[0]) begin
        ndone++;
        done_at = cnt;
        chk("busy_start out", 256'(out_v[0]), 256'(PT));
      end
    end
    chk("busy_start pulses", 256'(ndone), 256'd1);
    chk("busy_start latency", 256'(done_at), 256'd11);

    // Inputs scrambled right after acceptance.
    @(negedge clk);
    key_v = K128; cin = C128; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    key_v = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    cin   = {$urandom, $urandom, $urandom, $urandom};
    cnt = 1;
    while (!done_v[0] && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("indep latency", 256'(cnt), 256'd11);
    chk("indep out", 256'(out_v[0]), 256'(PT));

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    key_v = K128; cin = C128; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    cnt = 1;
    while (cnt < 6) begin
      @(posedge clk); #1;
      cnt++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst out", 256'(out_v[0]), 256'd0);
    chk("rst done", 256'(done_v[0]), 256'd0);
    chk("rst busy", 256'(busy_v[0]), 256'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_v[0]) ndone++;
    end
    chk("rst no late done", 256'(ndone), 256'd0);
    chk("rst out stays 0", 256'(out_v[0]), 256'd0);
    run_vec(0, K128, C128, PT, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
